pwm: RTL and testbench
======================

// Module: pwm
// PURPOSE
//  Pushbutton-adjustable PWM generator. Two buttons step the duty cycle up or
//  down; a free-running period counter compares against the active duty value
//  to drive a single PWM output. Sits between board pushbuttons and a load
//  (LED/motor driver) on one clock domain.
// PARAMETERS
//  PERIOD           10  clocks per PWM period (>=2)
//  STEP             1   duty change per accepted press, in clocks
//  DUTY_RST         0   duty value loaded on reset (0..PERIOD)
//  DEBOUNCE_CYCLES  4   stable cycles required per button (PWM_DEBOUNCE_EN only)
//  CW derived: $clog2(PERIOD+1), width of counter and duty registers
// PORTS
//  clk      in  1  system clock, rising edge
//  rst      in  1  asynchronous reset, active-low (rst=0 resets)
//  pb_inc   in  1  increment button, asynchronous, active-high
//  pb_dec   in  1  decrement button, asynchronous, active-high
//  pwm_out  out 1  PWM output, registered
// BEHAVIOUR
//  - Reset (rst=0, async): cnt=0, duty_next=duty_act=DUTY_RST, sync/edge
//    regs=0, pwm_out=0. Leaving reset: first period starts at cnt=0.
//  - Buttons: 2-FF synchronizer each, then rising-edge detect (prev reg).
//    One accepted press per 0->1 transition; holding gives no repeat.
//    1-cycle-wide pulses must be accepted.
//  - Latency: button high at edge k -> duty_next updated at edge k+3.
//  - duty_next: inc -> min(duty_next+STEP, PERIOD); dec -> max(duty_next-STEP, 0);
//    saturating, no wrap; compute in CW+1 bits. inc and dec accepted same
//    cycle -> no change.
//  - cnt: 0..PERIOD-1, wraps to 0. At wrap (cnt==PERIOD-1) duty_act<=duty_next,
//    so duty changes only at period boundaries (glitch-free).
//  - pwm_out registered: pwm_out <= (cnt_next < duty_act_next), i.e. high for
//    first duty_act clocks of each period. duty=0 -> constant 0;
//    duty=PERIOD -> constant 1, no low pulse.
//  - Reset mid-period: output drops to 0 immediately, pending press discarded.
// CONFIGURATION
//  PWM_DEBOUNCE_EN defined: after synchronizer each button passes a debouncer;
//    debounced level changes only after input stable DEBOUNCE_CYCLES
//    consecutive cycles; edge detect uses debounced level; latency +
//    DEBOUNCE_CYCLES; pulses shorter than DEBOUNCE_CYCLES ignored.
//  Undefined (default): no debouncer, synchronized level feeds edge detect.
// TESTING
//  1 Reset held 2 cycles, release -> pwm_out=0 constant for 2 full periods.
//  2 Two 1-cycle pb_inc pulses 10 cycles apart -> duty 0->1->2; after next
//    wrap pwm_out high 2 of every 10 clocks.
//  3 Two pb_dec pulses after 2 -> duty 0; pwm_out constant 0 from next period.
//  4 12 inc presses -> duty saturates 10, pwm_out constant 1; dec at 0 stays 0.
//  5 pb_inc and pb_dec same cycle -> duty unchanged; pb_inc held 50 cycles
//    -> exactly one step.
//  6 Press mid-period -> current period keeps old duty; new duty from next
//    cnt=0; rst=0 mid-high -> pwm_out=0 within same cycle (async).

Source files
------------

// File: rtl/pwm.sv
// pwm: pushbutton-adjustable PWM generator; duty steps up/down, applied at period boundaries.
// Optional PWM_DEBOUNCE_EN inserts a per-button debouncer after the synchronizers.
module pwm #(
  parameter int PERIOD          = 10,
  parameter int STEP            = 1,
  parameter int DUTY_RST        = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_inc,
  input  logic pb_dec,
  output logic pwm_out
);
  localparam int CW = $clog2(PERIOD + 1);
  localparam logic [CW:0] STEP_W = (CW+1)'(STEP);
  localparam logic [CW:0] PER_W  = (CW+1)'(PERIOD);

  // bit 0 = inc, bit 1 = dec
  logic [1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, edge_q, edge_d, lvl;
  logic [CW-1:0] cnt_q, cnt_d, duty_next_q, duty_next_d, duty_act_q, duty_act_d;
  logic [CW:0] up, dn;
  logic pwm_q, pwm_d, wrap;

`ifdef PWM_DEBOUNCE_EN
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [1:0] db_q, db_d;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    db_d   = db_q;
    dcnt_d = '0;
    for (int i = 0; i < 2; i++)
      if (s2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) db_d[i] = s2_q[i];
        else dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      db_q   <= '0;
      dcnt_q <= '0;
    end else begin
      db_q   <= db_d;
      dcnt_q <= dcnt_d;
    end

  assign lvl = db_q;
`else
  assign lvl = s2_q;
`endif

  always_comb begin
    s1_d   = {pb_dec, pb_inc};
    s2_d   = s1_q;
    prev_d = lvl;
    edge_d = lvl & ~prev_q;
    up     = {1'b0, duty_next_q} + STEP_W;
    dn     = {1'b0, duty_next_q} - STEP_W;
    duty_next_d = (edge_q[0] && !edge_q[1]) ? (up > PER_W ? CW'(PERIOD) : up[CW-1:0])
                : (edge_q[1] && !edge_q[0]) ? ({1'b0, duty_next_q} < STEP_W ? '0 : dn[CW-1:0])
                : duty_next_q;
    wrap       = cnt_q == CW'(PERIOD - 1);
    cnt_d      = wrap ? '0 : cnt_q + CW'(1);
    duty_act_d = wrap ? duty_next_q : duty_act_q;
    pwm_d      = cnt_d < duty_act_d;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      prev_q      <= '0;
      edge_q      <= '0;
      cnt_q       <= '0;
      duty_next_q <= CW'(DUTY_RST);
      duty_act_q  <= CW'(DUTY_RST);
      pwm_q       <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      prev_q      <= prev_d;
      edge_q      <= edge_d;
      cnt_q       <= cnt_d;
      duty_next_q <= duty_next_d;
      duty_act_q  <= duty_act_d;
      pwm_q       <= pwm_d;
    end

  assign pwm_out = pwm_q;
endmodule

// File: tb/tb_pwm.sv
// tb_pwm: directed and randomized checks of pwm against a period/duty reference model.
module tb_pwm;
  localparam int P = 10;
  logic clk = 0, rst = 0, pb_inc = 0, pb_dec = 0;
  logic pwm_out;
  int total = 0, bad = 0;
  int pos = 0, dnext = 0, dact = 0, hc;
  bit hi[5], hd[5];

  pwm dut (.clk(clk), .rst(rst), .pb_inc(pb_inc), .pb_dec(pb_dec), .pwm_out(pwm_out));

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    pos = 0; dnext = 0; dact = 0;
    for (int i = 0; i < 5; i++) begin hi[i] = 0; hd[i] = 0; end
  endtask

  // A press is a 0->1 input change; it lands in duty three edges after being sampled.
  task automatic step(string tag);
    bit ai, ad;
    @(posedge clk);
    if (!rst) mreset();
    else begin
      for (int i = 4; i > 0; i--) begin hi[i] = hi[i-1]; hd[i] = hd[i-1]; end
      hi[0] = pb_inc; hd[0] = pb_dec;
      ai = hi[3] && !hi[4];
      ad = hd[3] && !hd[4];
      pos = (pos + 1) % P;
      if (pos == 0) dact = dnext;
      if (ai && !ad) dnext = (dnext + 1 > P) ? P : dnext + 1;
      if (ad && !ai) dnext = (dnext == 0) ? 0 : dnext - 1;
    end
    #1 chk(tag, int'(pwm_out), int'(pos < dact));
  endtask

  task automatic run(bit inc, bit dec, int n, string tag);
    for (int i = 0; i < n; i++) begin
      pb_inc = inc; pb_dec = dec;
      step(tag);
    end
  endtask

  task automatic count_high(int exp, string tag);
    hc = 0;
    for (int i = 0; i < P; i++) begin
      step(tag);
      hc += int'(pwm_out);
    end
    chk(tag, hc, exp);
  endtask

  initial begin
    mreset();
    run(0, 0, 2, "reset");
    rst = 1;
    run(0, 0, 20, "idle");
    count_high(0, "idle_hc");
    run(1, 0, 1, "inc1"); run(0, 0, 9, "inc1");
    run(1, 0, 1, "inc2"); run(0, 0, 19, "inc2");
    count_high(2, "duty2_hc");
    run(0, 1, 1, "dec1"); run(0, 0, 9, "dec1");
    run(0, 1, 1, "dec2"); run(0, 0, 19, "dec2");
    count_high(0, "duty0_hc");
    for (int k = 0; k < 12; k++) begin run(1, 0, 1, "sat_inc"); run(0, 0, 1, "sat_inc"); end
    run(0, 0, 20, "sat_inc");
    count_high(P, "duty_full_hc");
    count_high(P, "duty_full_hc2");
    for (int k = 0; k < 13; k++) begin run(0, 1, 1, "sat_dec"); run(0, 0, 1, "sat_dec"); end
    run(0, 0, 20, "sat_dec");
    count_high(0, "duty_floor_hc");
    run(1, 1, 1, "both"); run(0, 0, 20, "both");
    count_high(0, "both_hc");
    run(1, 0, 50, "hold"); run(0, 0, 20, "hold");
    count_high(1, "hold_hc");
    for (int k = 0; k < 4; k++) begin run(1, 0, 1, "to5"); run(0, 0, 1, "to5"); end
    run(0, 0, 3, "midper");
    run(1, 0, 1, "midper"); run(0, 0, 25, "midper");
    count_high(6, "duty6_hc");
    for (int i = 0; i < 20 && pwm_out !== 1'b1; i++) step("seek_high");
    chk("mid_high", int'(pwm_out), 1);
    #2 rst = 0;
    #1 chk("async_rst", int'(pwm_out), 0);
    mreset();
    run(1, 0, 2, "in_rst");
    rst = 1;
    run(0, 0, 20, "post_rst");
    count_high(0, "post_rst_hc");
    for (int c = 0; c < 3000; c++) begin
      pb_inc = ($urandom_range(0, 5) == 0);
      pb_dec = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst = 0;
        run(0, 0, $urandom_range(1, 3), "rand_rst");
        rst = 1;
      end else step("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
